coso_config_search: RTL and testbench

- Next-generation configuration search controller for the COSO TRNG.
- Scores every RO0/RO1 configuration over a window of coherent-sampler counter values. Runtime-selectable first-fit or best-fit search.
- Monitors the locked configuration continuously and re-searches automatically after sustained loss of lock.
- Sits between the coherent sampler (CSCnt/CSReq/CSAck handshake) and the two configurable ring oscillators.

---
 rtl/coso_config_search_if.sv | 12 +
 rtl/coso_config_search.sv | 196 +++++++++++++++++++
 tb/tb_coso_config_search.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/coso_config_search_if.sv
// Coherent-sampler handshake bundle (CSCnt/CSReq/CSAck) between the sampler and
// the configuration search controller.
interface coso_config_search_if #(
  parameter int unsigned CSCntLength = 16
) ();
  logic [CSCntLength-1:0] CSCnt;
  logic                   CSReq;
  logic                   CSAck;

  modport master (output CSCnt, output CSReq, input CSAck);
  modport slave  (input CSCnt, input CSReq, output CSAck);
endinterface

// File: rtl/coso_config_search.sv
// COSO TRNG configuration search: scores every RO0/RO1 configuration over a window of
// coherent-sampler counts, first-fit or best-fit, and re-searches after sustained lock loss.
module coso_config_search #(
  parameter int unsigned CSCntLength  = 16,
  parameter int unsigned NBCheckbits  = 10,
  parameter int unsigned ROLength     = 3,
  parameter int unsigned NBSamplesLog = 4,
  parameter int unsigned LockLossMax  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  coso_config_search_if.slave       cs,
  input  logic                      start,
  input  logic                      mode,
  input  logic [NBCheckbits-1:0]    threshL,
  input  logic [NBCheckbits-1:0]    threshH,
  input  logic [NBSamplesLog:0]     samplesMin,
  output logic [2*ROLength-1:0]     RO0Sel,
  output logic [2*ROLength-1:0]     RO1Sel,
  output logic                      matched,
  output logic                      noFound,
  output logic                      busy,
  output logic [NBSamplesLog:0]     bestScore
);
  localparam int unsigned CW = 4 * ROLength;
  localparam int unsigned SW = NBSamplesLog + 1;
  localparam int unsigned LW = $clog2(LockLossMax + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] FAILED = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cfg_q, cfg_d, best_cfg_q, best_cfg_d;
  logic [NBSamplesLog-1:0] smp_q, smp_d;
  logic [SW-1:0]           good_q, good_d, best_q, best_d;
  logic [LW-1:0]           loss_q, loss_d;
  logic                    ack_q, ack_d, matched_q, matched_d;
  logic                    nofound_q, nofound_d, busy_q, busy_d;
  logic [NBCheckbits-1:0]  thl_q, thl_d, thh_q, thh_d;
  logic [SW-1:0]           smin_q, smin_d;
  logic                    mode_q, mode_d;

  logic [NBCheckbits-1:0] top;
  logic                   cnt_unused;
  logic                   accept, active, win_end, is_good, last_cfg, better, relock;
  logic [SW-1:0]          score;

  assign top        = cs.CSCnt[CSCntLength-1 -: NBCheckbits];
  assign cnt_unused = ^cs.CSCnt;
  assign accept     = cs.CSReq & ~ack_q;
  assign active     = (state_q == SEARCH) || (state_q == LOCKED);
  assign win_end    = accept & active & (&smp_q);
  // An empty or inverted threshold range naturally yields no good samples.
  assign is_good    = (top >= thl_q) && (top < thh_q);
  assign score      = good_q + SW'(is_good);
  assign last_cfg   = &cfg_q;
  assign better     = score > best_q;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    best_cfg_d = best_cfg_q;
    smp_d      = smp_q;
    good_d     = good_q;
    best_d     = best_q;
    loss_d     = loss_q;
    matched_d  = matched_q;
    nofound_d  = nofound_q;
    busy_d     = busy_q;
    thl_d      = thl_q;
    thh_d      = thh_q;
    smin_d     = smin_q;
    mode_d     = mode_q;
    relock     = 1'b0;
    ack_d      = accept;

    if (accept && active) begin
      smp_d  = smp_q + 1'b1;
      good_d = win_end ? '0 : score;
    end

    if (win_end) begin
      case (state_q)
        SEARCH: begin
          if (!mode_q) begin
            if (better) best_d = score;
            if (score >= smin_q) begin
              state_d   = LOCKED;
              matched_d = 1'b1;
              busy_d    = 1'b0;
            end else if (last_cfg) begin
              state_d   = FAILED;
              nofound_d = 1'b1;
              busy_d    = 1'b0;
            end else begin
              cfg_d = cfg_q + 1'b1;
            end
          end else begin
            // Strict compare keeps the earliest configuration on ties.
            if (better) begin
              best_d     = score;
              best_cfg_d = cfg_q;
            end
            if (last_cfg) begin
              busy_d = 1'b0;
              if (best_d >= smin_q) begin
                cfg_d     = best_cfg_d;
                state_d   = LOCKED;
                matched_d = 1'b1;
              end else begin
                state_d   = FAILED;
                nofound_d = 1'b1;
              end
            end else begin
              cfg_d = cfg_q + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (score < (smin_q >> 1)) begin
            if (loss_q + 1'b1 == LW'(LockLossMax)) relock = 1'b1;
            else loss_d = loss_q + 1'b1;
          end else begin
            loss_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (start || relock) begin
      state_d    = SEARCH;
      cfg_d      = '0;
      best_cfg_d = '0;
      best_d     = '0;
      smp_d      = '0;
      good_d     = '0;
      loss_d     = '0;
      matched_d  = 1'b0;
      nofound_d  = 1'b0;
      busy_d     = 1'b1;
    end
    if (start) begin
      thl_d  = threshL;
      thh_d  = threshH;
      smin_d = samplesMin;
      mode_d = mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      best_cfg_q <= '0;
      smp_q      <= '0;
      good_q     <= '0;
      best_q     <= '0;
      loss_q     <= '0;
      ack_q      <= 1'b0;
      matched_q  <= 1'b0;
      nofound_q  <= 1'b0;
      busy_q     <= 1'b0;
      thl_q      <= '0;
      thh_q      <= '0;
      smin_q     <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      best_cfg_q <= best_cfg_d;
      smp_q      <= smp_d;
      good_q     <= good_d;
      best_q     <= best_d;
      loss_q     <= loss_d;
      ack_q      <= ack_d;
      matched_q  <= matched_d;
      nofound_q  <= nofound_d;
      busy_q     <= busy_d;
      thl_q      <= thl_d;
      thh_q      <= thh_d;
      smin_q     <= smin_d;
      mode_q     <= mode_d;
    end
  end

  assign cs.CSAck  = ack_q;
  assign RO0Sel    = cfg_q[2*ROLength-1:0];
  assign RO1Sel    = cfg_q[CW-1:2*ROLength];
  assign matched   = matched_q;
  assign noFound   = nofound_q;
  assign busy      = busy_q;
  assign bestScore = best_q;
endmodule

// File: tb/tb_coso_config_search.sv
// Self-checking bench for coso_config_search: directed scenarios plus randomized searches
// checked against a score-table model of first-fit / best-fit selection.
module tb_coso_config_search;
  localparam int unsigned CL = 8, NB = 4, ROL = 1, NSL = 2, LossMax = 2;

  logic clk = 1'b0;
  logic rst;
  logic start, mode;
  logic [NB-1:0]    threshL, threshH;
  logic [NSL:0]     samplesMin;
  logic [2*ROL-1:0] RO0Sel, RO1Sel;
  logic             matched, noFound, busy;
  logic [NSL:0]     bestScore;

  always #5 clk = ~clk;

  coso_config_search_if #(.CSCntLength(CL)) cs_if ();

  coso_config_search #(
    .CSCntLength(CL), .NBCheckbits(NB), .ROLength(ROL), .NBSamplesLog(NSL), .LockLossMax(LossMax)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs_if), .start(start), .mode(mode),
    .threshL(threshL), .threshH(threshH), .samplesMin(samplesMin),
    .RO0Sel(RO0Sel), .RO1Sel(RO1Sel), .matched(matched), .noFound(noFound),
    .busy(busy), .bestScore(bestScore)
  );

  int checks = 0;
  int errors = 0;
  int scores[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int em, input int enf, input int ecw,
                            input int ebest, input int ebusy);
    check({tag, ".matched"}, 32'(matched), 32'(em));
    check({tag, ".noFound"}, 32'(noFound), 32'(enf));
    check({tag, ".cfg"}, 32'({RO1Sel, RO0Sel}), 32'(ecw));
    check({tag, ".bestScore"}, 32'(bestScore), 32'(ebest));
    check({tag, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  // One accepted sample: two cycles, CSAck must be high right after acceptance.
  task automatic send(input logic [7:0] v);
    cs_if.CSCnt = v;
    cs_if.CSReq = 1'b1;
    @(posedge clk); #1;
    check("ack", 32'(cs_if.CSAck), 32'd1);
    cs_if.CSReq = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] mk(input bit g, input int tl, input int th);
    int nib;
    if (g) nib = $urandom_range(th - 1, tl);
    else if (tl > 0 && $urandom_range(1, 0) == 1) nib = $urandom_range(tl - 1, 0);
    else nib = $urandom_range(15, th);
    return {nib[3:0], 4'($urandom)};
  endfunction

  task automatic send_window(input int s, input int tl, input int th);
    int rem = s;
    for (int k = 0; k < 4; k++) begin
      bit g;
      g = (rem > 0) && ((rem == 4 - k) || ($urandom_range(1, 0) == 1));
      if (g) rem--;
      send(mk(g, tl, th));
    end
  endtask

  task automatic do_start(input bit m, input int tl, input int th, input int sm);
    mode = m; threshL = 4'(tl); threshH = 4'(th); samplesMin = 3'(sm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Latched at start; later changes must not matter.
    mode = ~m; threshL = 4'($urandom); threshH = 4'($urandom); samplesMin = 3'($urandom);
    check_outs("start", 0, 0, 0, 0, 1);
  endtask

  task automatic model(input bit m, input int sm, output int em, output int enf,
                       output int ecw, output int ebest, output int nwin);
    int bi;
    em = 0; enf = 0; ecw = 15; ebest = 0; nwin = 16; bi = 0;
    if (!m) begin
      for (int i = 0; i < 16; i++) begin
        if (scores[i] > ebest) ebest = scores[i];
        if (scores[i] >= sm) begin
          em = 1; ecw = i; nwin = i + 1;
          break;
        end
      end
      if (em == 0) enf = 1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (scores[i] > ebest) begin ebest = scores[i]; bi = i; end
      end
      if (ebest >= sm) begin em = 1; ecw = bi; end
      else enf = 1;
    end
  endtask

  task automatic run_case(input string tag, input bit m, input int tl, input int th,
                          input int sm);
    int em, enf, ecw, ebest, nwin;
    model(m, sm, em, enf, ecw, ebest, nwin);
    do_start(m, tl, th, sm);
    for (int i = 0; i < nwin; i++) send_window(scores[i], tl, th);
    check_outs(tag, em, enf, ecw, ebest, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, consec;
    bit prev;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    threshL = '0; threshH = '0; samplesMin = '0;
    cs_if.CSReq = 1'b0; cs_if.CSCnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset.ack", 32'(cs_if.CSAck), 32'd0);

    // 1: first-fit, config 5 is the first to pass.
    for (int i = 0; i < 16; i++) scores[i] = 0;
    scores[5] = 4;
    run_case("ff_cfg5", 1'b0, 4, 8, 3);

    // 2: best-fit, config 9 beats config 3.
    for (int i = 0; i < 16; i++) scores[i] = 0;
    scores[3] = 3; scores[9] = 4;
    run_case("bf_cfg9", 1'b1, 4, 8, 3);

    // 3: nibble 8 is just outside [4,8), sweep fails; then nibble 4 is inside.
    do_start(1'b0, 4, 8, 3);
    for (int i = 0; i < 64; i++) send({4'd8, 4'($urandom)});
    check_outs("boundary_hi", 0, 1, 15, 0, 0);
    do_start(1'b0, 4, 8, 3);
    for (int i = 0; i < 4; i++) send({4'd4, 4'($urandom)});
    check_outs("boundary_lo", 1, 0, 0, 4, 0);

    // 4: lock loss; S < 3>>1 means only S=0 windows count as weak.
    send_window(0, 4, 8);
    send_window(1, 4, 8);
    send_window(0, 4, 8);
    check_outs("loss_cleared", 1, 0, 0, 4, 0);
    send_window(0, 4, 8);
    check_outs("loss_relock", 0, 0, 0, 0, 1);
    send_window(4, 4, 8);
    check_outs("relocked", 1, 0, 0, 4, 0);
    send_window(0, 4, 8);
    send_window(4, 4, 8);
    send_window(0, 4, 8);
    check_outs("weak_strong_weak", 1, 0, 0, 4, 0);

    // Inverted thresholds: nothing is good; samplesMin=0 passes anyway.
    do_start(1'b0, 9, 5, 1);
    for (int i = 0; i < 64; i++) send({4'd6, 4'($urandom)});
    check_outs("inverted", 0, 1, 15, 0, 0);
    do_start(1'b0, 9, 5, 0);
    for (int i = 0; i < 4; i++) send({4'd6, 4'($urandom)});
    check_outs("smin0_ff", 1, 0, 0, 0, 0);

    // Randomized searches against the score-table model.
    for (int t = 0; t < 10; t++) begin
      bit m;
      int tl, th, sm;
      m  = 1'($urandom);
      tl = $urandom_range(7, 1);
      th = $urandom_range(15, tl + 1);
      sm = $urandom_range(4, 0);
      for (int i = 0; i < 16; i++)
        scores[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(4, 0) : $urandom_range(1, 0);
      run_case($sformatf("rand%0d", t), m, tl, th, sm);
    end

    // 6: reset mid-search at config 6.
    for (int i = 0; i < 16; i++) scores[i] = 0;
    do_start(1'b0, 4, 8, 3);
    for (int i = 0; i < 6; i++) send_window(0, 4, 8);
    check_outs("pre_rst", 0, 0, 6, 0, 1);
    send({4'd5, 4'd0});
    send({4'd5, 4'd0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outs("mid_rst", 0, 0, 0, 0, 0);
    check("mid_rst.ack", 32'(cs_if.CSAck), 32'd0);

    // 5: CSReq held high for 5 cycles in IDLE.
    acks = 0; consec = 0; prev = 1'b0;
    cs_if.CSCnt = {4'd5, 4'd0};
    cs_if.CSReq = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (cs_if.CSAck) acks++;
      if (cs_if.CSAck && prev) consec++;
      prev = cs_if.CSAck;
    end
    cs_if.CSReq = 1'b0;
    @(posedge clk); #1;
    check("held.acks", 32'(acks), 32'd3);
    check("held.consec", 32'(consec), 32'd0);
    check("held.ack_low", 32'(cs_if.CSAck), 32'd0);
    for (int i = 0; i < 8; i++) send({4'd5, 4'($urandom)});
    check_outs("idle_discard", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
